seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 235 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Latency: 1 cycle for single-cycle ops (incl. DIV by zero), W+1 cycles for MUL/DIV.
// Backpressure: result and flags hold in DONE until out_ready; no new command until IDLE.
// Optional feature: define SEQ_ALU_ROTATE_EN to build the ROL/ROR rotators (opcodes E/F).
module seq_alu #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opco,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   result,
    output logic             carryflag,
    output logic             zeroflag,
    output logic             errflag,
    output logic             busy
);

    localparam int SW = $clog2(W);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_ROL  = 4'hE;
    localparam logic [3:0] OP_ROR  = 4'hF;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nx;

    // Iterative datapath state: MUL uses acc/mcand/mplier, DIV uses rem/quo/dvs.
    logic [SW-1:0]  cnt;
    logic           is_div;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [W-1:0]   rem;
    logic [W-1:0]   quo;
    logic [W-1:0]   dvs;

    logic           accept;
    logic           multi;
    logic           last_step;

    // Single-cycle ALU outputs, computed straight from the command inputs.
    logic [2*W-1:0] alu_res;
    logic           alu_c;
    logic           alu_e;
    logic [W:0]     sum;
    logic [SW-1:0]  sh;
    logic [2*W-1:0] rot2;

    // One iteration of the shift-add multiplier and restoring divider.
    logic [2*W-1:0] mul_nx;
    logic [W:0]     div_sh;
    logic [W-1:0]   rem_nx;
    logic [W-1:0]   quo_nx;
    logic [2*W-1:0] fin_res;

    assign accept    = in_valid && (state == IDLE);
    assign multi     = (opco == OP_MUL) || ((opco == OP_DIV) && (b != '0));
    assign last_step = (state == BUSY) && (cnt == SW'(W - 1));
    assign sum       = {1'b0, a} + {1'b0, b};
    assign sh        = b[SW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_nx = multi ? BUSY : DONE;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle operations; W-bit results are zero-extended to 2W.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_e   = 1'b0;
        rot2    = '0;
        case (opco)
            OP_ADD: begin
                alu_res = {{W{1'b0}}, sum[W-1:0]};
                alu_c   = sum[W];
            end
            OP_SUB: begin
                alu_res = {{W{1'b0}}, a - b};
                alu_c   = (a < b);
            end
            OP_DIV: begin
                // Only reaches here with b==0: quotient saturates, remainder is the dividend.
                alu_res = {a, {W{1'b1}}};
                alu_e   = 1'b1;
            end
            OP_AND:  alu_res = {{W{1'b0}}, a & b};
            OP_OR:   alu_res = {{W{1'b0}}, a | b};
            OP_NOT:  alu_res = {{W{1'b0}}, ~a};
            OP_NAND: alu_res = {{W{1'b0}}, ~(a & b)};
            OP_NOR:  alu_res = {{W{1'b0}}, ~(a | b)};
            OP_XOR:  alu_res = {{W{1'b0}}, a ^ b};
            OP_CMP: begin
                alu_res = {{(2*W-2){1'b0}}, (a > b), (a < b)};
                alu_c   = (a < b);
            end
            OP_SHL:  alu_res = {{W{1'b0}}, a << sh};
            OP_SHR:  alu_res = {{W{1'b0}}, a >> sh};
`ifdef SEQ_ALU_ROTATE_EN
            OP_ROL: begin
                rot2    = {a, a} << sh;
                alu_res = {{W{1'b0}}, rot2[2*W-1:W]};
            end
            OP_ROR: begin
                rot2    = {a, a} >> sh;
                alu_res = {{W{1'b0}}, rot2[W-1:0]};
            end
`else
            OP_ROL, OP_ROR: begin
                alu_res = '0;
                alu_e   = 1'b1;
            end
`endif
            default: alu_res = '0;
        endcase
    end

    // One multiplier/divider step, plus the final result on the last step.
    always_comb begin
        mul_nx = mplier[0] ? (acc + mcand) : acc;
        div_sh = {rem, quo[W-1]};
        rem_nx = div_sh[W-1:0];
        quo_nx = {quo[W-2:0], 1'b0};
        if (div_sh >= {1'b0, dvs}) begin
            rem_nx = W'(div_sh - {1'b0, dvs});
            quo_nx = {quo[W-2:0], 1'b1};
        end
        fin_res = is_div ? {rem_nx, quo_nx} : mul_nx;
    end

    // Datapath and status registers; everything holds while waiting in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            carryflag <= 1'b0;
            zeroflag  <= 1'b0;
            errflag   <= 1'b0;
            cnt       <= '0;
            is_div    <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
        end else if (accept) begin
            if (multi) begin
                cnt    <= '0;
                is_div <= (opco == OP_DIV);
                acc    <= '0;
                mcand  <= {{W{1'b0}}, a};
                mplier <= b;
                rem    <= '0;
                quo    <= a;
                dvs    <= b;
            end else if (opco == OP_NOP) begin
                carryflag <= 1'b0;
                zeroflag  <= 1'b1;
                errflag   <= 1'b0;
            end else begin
                result    <= alu_res;
                carryflag <= alu_c;
                zeroflag  <= (alu_res == '0);
                errflag   <= alu_e;
            end
        end else if (state == BUSY) begin
            cnt    <= cnt + 1'b1;
            acc    <= mul_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_nx;
            quo    <= quo_nx;
            if (last_step) begin
                result    <= fin_res;
                carryflag <= is_div ? 1'b0 : (mul_nx[2*W-1:W] != '0);
                zeroflag  <= (fin_res == '0);
                errflag   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases then randomized commands.
// Expected responses come from an arithmetic reference model, pushed at acceptance.
// A decoupled monitor checks latency, stability under backpressure and handshake rules.
module tb_seq_alu;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] res;
        logic           c;
        logic           z;
        logic           e;
        int             lat;
        int             acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     opco;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           carryflag;
    logic           zeroflag;
    logic           errflag;
    logic           busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];
    logic [2*W-1:0] last_res = '0;
    logic bp_hold = 1'b0;
    logic rand_bp = 1'b0;

    // Monitor state.
    int   busy_cnt = 0;
    logic seen     = 1'b0;
    logic chk_ir   = 1'b0;

    seq_alu #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opco(opco), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carryflag(carryflag), .zeroflag(zeroflag),
        .errflag(errflag), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the operand values.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb);
        exp_t e;
        longint unsigned ua, ub, m, r, s;
        int sa;
        ua = longint'(xa);
        ub = longint'(xb);
        m  = (64'd1 << W) - 1;
        sa = int'(ub % W);
        e.c = 1'b0; e.e = 1'b0; e.lat = 1; e.acc = 0;
        r = 0;
        case (op)
            4'h0: r = longint'(last_res);
            4'h1: begin s = ua + ub; r = s & m; e.c = (s > m); end
            4'h2: begin r = (ua - ub) & m; e.c = (ua < ub); end
            4'h3: begin r = ua * ub; e.c = (r > m); e.lat = W + 1; end
            4'h4: begin
                if (ub == 0) begin r = (ua << W) | m; e.e = 1'b1; end
                else begin r = ((ua % ub) << W) | (ua / ub); e.lat = W + 1; end
            end
            4'h5: r = ua & ub;
            4'h6: r = ua | ub;
            4'h7: r = ~ua & m;
            4'h8: r = ~(ua & ub) & m;
            4'h9: r = ~(ua | ub) & m;
            4'hA: r = ua ^ ub;
            4'hB: begin r = (ua > ub) ? 2 : ((ua < ub) ? 1 : 0); e.c = (ua < ub); end
            4'hC: r = (ua << sa) & m;
            4'hD: r = ua >> sa;
`ifdef SEQ_ALU_ROTATE_EN
            4'hE: r = ((ua << sa) | (ua >> (W - sa))) & m;
            4'hF: r = ((ua >> sa) | (ua << (W - sa))) & m;
`else
            4'hE, 4'hF: begin r = 0; e.e = 1'b1; end
`endif
            default: r = 0;
        endcase
        e.res = r[2*W-1:0];
        e.z   = (op == 4'h0) ? 1'b1 : (r == 0);
        return e;
    endfunction

    task automatic send(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb);
        exp_t e;
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; opco = op; a = xa; b = xb;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        e = model(op, xa, xb);
        e.acc = cyc;
        last_res = e.res;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_flags"}, {carryflag, zeroflag, errflag}, 3'b000);
    endtask

    // Output monitor: compares every DONE cycle against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            seen     = 1'b0;
            chk_ir   = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (chk_ir) begin
                check("ready_after_handshake", {in_ready, out_valid}, 2'b10);
                chk_ir = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        check("latency", cyc - sb[0].acc, sb[0].lat);
                        check("busy_cycles", busy_cnt, sb[0].lat - 1);
                    end
                    check("result", result, sb[0].res);
                    check("carryflag", carryflag, sb[0].c);
                    check("zeroflag", zeroflag, sb[0].z);
                    check("errflag", errflag, sb[0].e);
                    check("in_ready_in_done", in_ready, 0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen     = 1'b0;
                        busy_cnt = 0;
                        chk_ir   = 1'b1;
                    end
                end
            end
        end
    end

    // Result-side backpressure driver.
    initial begin
        forever begin
            @(posedge clk);
            #2 out_ready = bp_hold ? 1'b0 : (rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    initial begin
        int n;
        logic [3:0] rop;
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; opco = '0; a = '0; b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        send(4'h1, 8'hFF, 8'h01);   // ADD wraps to zero with carry
        send(4'h3, 8'hFF, 8'hFF);   // MUL full product 0xFE01
        send(4'h4, 8'd200, 8'd7);   // DIV -> {4, 28}
        send(4'h4, 8'd200, 8'd0);   // DIV by zero
        send(4'h2, 8'h10, 8'h20);   // SUB with borrow
        send(4'hB, 8'h33, 8'h33);   // CMP equal -> zero
        send(4'hB, 8'h40, 8'h10);   // CMP greater
        send(4'hC, 8'h81, 8'h03);   // SHL
        send(4'hD, 8'h81, 8'h00);   // SHR by 0 returns a
        send(4'hE, 8'h81, 8'h01);   // ROL
        send(4'hF, 8'h81, 8'h01);   // ROR
        send(4'h3, 8'h00, 8'h5A);   // MUL zero
        drain();

        // Backpressure: result must stay put while out_ready is low.
        bp_hold = 1'b1;
        out_ready = 1'b0;
        send(4'hA, 8'hA5, 8'h0F);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", out_valid, 1);
        repeat (5) @(posedge clk);
        bp_hold = 1'b0;
        drain();
        send(4'h0, 8'h12, 8'h34);   // NOP keeps 0x00AA
        drain();

        // Reset during the third BUSY cycle of a MUL discards it.
        send(4'h3, 8'h0F, 8'h0F);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        last_res = '0;
        check_reset_state("abort");
        send(4'h1, 8'd1, 8'd2);
        drain();

        // Randomized commands with random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            send(rop, ra, rb);
        end
        drain();
        rand_bp = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
